// File: rtl/sfft_pkg.sv
// Shared constants for the audio front end and the SFFT pipeline.
// No logic; types and defaults only.
// Bin-frequency scaling in SFFT_Pipeline reuses DECIM_LOG2_DEF.
package sfft_pkg;
  localparam int SAMPLE_W       = 24;
  localparam int DECIM_LOG2_DEF = 2;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with full/empty/count and a read port that holds its last popped word.
// Latency: a write is visible at the read port the cycle after it is accepted.
// Backpressure: writes are refused when full, unless a read happens in the same cycle.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] hold_q;
  logic             do_rd;
  logic             do_wr;

  assign count  = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd  = rd_en && !empty;
  assign do_wr  = wr_en && (!full || do_rd);
  // When drained, the port keeps showing the last word handed out.
  assign rd_dat = empty ? hold_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        hold_q <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/audio_decimator.sv
// Stereo-to-mono averaging and box-car decimation of codec samples into a valid/ready FIFO.
// Latency: 3 cycles from the advance edge of a group's last sample to sample_valid.
// Backpressure: pipeline never stalls; a result arriving at a full FIFO is dropped and counted.
module audio_decimator
  import sfft_pkg::*;
#(
  parameter int IN_W       = SAMPLE_W,
  parameter int DECIM_LOG2 = DECIM_LOG2_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] adc_left,
  input  logic [IN_W-1:0] adc_right,
  input  logic            advance,
  input  logic            enable,
  output logic [IN_W-1:0] sample_out,
  output logic            sample_valid,
  input  logic            sample_ready,
  output logic [15:0]     overflow_count
);
  localparam int ACC_W = IN_W + DECIM_LOG2;
  localparam int PH_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'((1 << DECIM_LOG2) - 1);

  logic                    advance_q;
  logic                    adv_edge;
  logic                    cap_vld;
  logic [IN_W-1:0]         cap_l;
  logic [IN_W-1:0]         cap_r;
  logic [IN_W:0]           mono_sum;
  logic                    mono_vld;
  logic signed [IN_W-1:0]  mono_q;
  logic signed [ACC_W-1:0] mono_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [PH_W-1:0]         phase_q;
  logic                    push;
  logic [IN_W-1:0]         avg_dat;
  logic                    pop;
  logic                    push_ok;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign adv_edge = advance && !advance_q && enable;

  // One extra bit holds L+R exactly; dropping bit 0 is the floor halving.
  assign mono_sum = {cap_l[IN_W-1], cap_l} + {cap_r[IN_W-1], cap_r};
  assign mono_ext = ACC_W'(mono_q);
  assign acc_nxt  = (phase_q == '0) ? mono_ext : acc_q + mono_ext;
  assign push     = mono_vld && enable && (phase_q == PH_LAST);
  assign avg_dat  = IN_W'(acc_nxt >>> DECIM_LOG2);

  assign sample_valid = !fifo_empty;
  assign pop          = sample_valid && sample_ready;
  assign push_ok      = !fifo_full || pop;

  // advance_q resets high so a strobe held through reset release is not a new sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) advance_q <= 1'b1;
    else       advance_q <= advance;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_vld  <= 1'b0;
      cap_l    <= '0;
      cap_r    <= '0;
      mono_vld <= 1'b0;
      mono_q   <= '0;
      acc_q    <= '0;
      phase_q  <= '0;
    end else if (!enable) begin
      cap_vld  <= 1'b0;
      mono_vld <= 1'b0;
      acc_q    <= '0;
      phase_q  <= '0;
    end else begin
      cap_vld  <= adv_edge;
      if (adv_edge) begin
        cap_l <= adc_left;
        cap_r <= adc_right;
      end
      mono_vld <= cap_vld;
      if (cap_vld) mono_q <= mono_sum[IN_W:1];
      if (mono_vld) begin
        acc_q   <= acc_nxt;
        phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_count <= '0;
    else if (push && !push_ok && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IN_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (push),
    .wr_dat (avg_dat),
    .rd_en  (pop),
    .rd_dat (sample_out),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assert property (@(posedge clk) disable iff (reset) int'(fifo_count) <= FIFO_DEPTH);
endmodule

// File: tb/tb_audio_decimator.sv
// Bench for audio_decimator: pass-through and decimate-by-4 instances share the stimulus.
// Stimulus queues expected averages with their push cycle; a negedge monitor models the FIFO and compares.
`timescale 1ns/1ps
module tb_audio_decimator;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        advance = 1'b1;
  logic        enable = 1'b1;
  logic        sample_ready = 1'b1;
  logic [23:0] adc_left = '0;
  logic [23:0] adc_right = '0;
  logic [23:0] out0, out2;
  logic        vld0, vld2;
  logic [15:0] ovf0, ovf2;

  always #10 clk = ~clk;

  audio_decimator #(.IN_W(24), .DECIM_LOG2(0), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .reset(reset), .adc_left(adc_left), .adc_right(adc_right),
    .advance(advance), .enable(enable), .sample_out(out0), .sample_valid(vld0),
    .sample_ready(sample_ready), .overflow_count(ovf0)
  );

  audio_decimator #(.IN_W(24), .DECIM_LOG2(2), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .reset(reset), .adc_left(adc_left), .adc_right(adc_right),
    .advance(advance), .enable(enable), .sample_out(out2), .sample_valid(vld2),
    .sample_ready(sample_ready), .overflow_count(ovf2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state, index 0 = pass-through, 1 = decimate by 4.
  int          dl [2] = '{0, 2};
  longint      grp_sum [2];
  int          grp_n [2];
  int          pend_due [2][64];
  logic [23:0] pend_val [2][64];
  int          pend_wr [2];
  int          pend_rd [2];
  logic [23:0] mq [2][DEPTH];
  int          mq_hd [2];
  int          mq_n [2];
  int          drops [2];
  logic [23:0] last_out [2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      grp_sum[k] = 0; grp_n[k] = 0; pend_wr[k] = 0; pend_rd[k] = 0;
      mq_hd[k] = 0; mq_n[k] = 0; drops[k] = 0; last_out[k] = '0;
    end
  endtask

  // Mono is floor((L+R)/2); a group's output is floor(sum / 2**D), pushed two cycles after its last edge.
  task automatic model_edge(logic [23:0] l, logic [23:0] r, int c);
    longint lv, rv, m;
    logic [63:0] a;
    lv = longint'($signed(l));
    rv = longint'($signed(r));
    m  = (lv + rv) >>> 1;
    for (int k = 0; k < 2; k++) begin
      grp_sum[k] = (grp_n[k] == 0) ? m : grp_sum[k] + m;
      grp_n[k]++;
      if (grp_n[k] == (1 << dl[k])) begin
        a = grp_sum[k] >>> dl[k];
        pend_due[k][pend_wr[k] % 64] = c + 2;
        pend_val[k][pend_wr[k] % 64] = a[23:0];
        pend_wr[k]++;
        grp_n[k] = 0;
      end
    end
  endtask

  task automatic mon_step(int k, logic vld, logic [23:0] dat, logic [15:0] ovf);
    chk($sformatf("valid_d%0d", dl[k]), {31'd0, vld}, {31'd0, mq_n[k] != 0});
    if (mq_n[k] != 0) chk($sformatf("head_d%0d", dl[k]), {8'd0, dat}, {8'd0, mq[k][mq_hd[k]]});
    else              chk($sformatf("hold_d%0d", dl[k]), {8'd0, dat}, {8'd0, last_out[k]});
    chk($sformatf("overflow_d%0d", dl[k]), {16'd0, ovf}, drops[k]);
    if (mq_n[k] != 0 && sample_ready) begin
      last_out[k] = mq[k][mq_hd[k]];
      mq_hd[k] = (mq_hd[k] + 1) % DEPTH;
      mq_n[k]--;
    end
    while (pend_rd[k] != pend_wr[k] && pend_due[k][pend_rd[k] % 64] <= cyc) begin
      if (mq_n[k] < DEPTH) begin
        mq[k][(mq_hd[k] + mq_n[k]) % DEPTH] = pend_val[k][pend_rd[k] % 64];
        mq_n[k]++;
      end else if (drops[k] < 65535) begin
        drops[k]++;
      end
      pend_rd[k]++;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon_step(0, vld0, out0, ovf0);
      mon_step(1, vld2, out2, ovf2);
    end
  end

  always @(posedge clk) begin
    if (cyc > 50000) begin
      $display("FAIL watchdog: cycle %0d exceeded budget 50000", cyc);
      $fatal(1, "watchdog");
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [23:0] l, logic [23:0] r, int hold, int gap);
    adc_left = l; adc_right = r; advance = 1'b1;
    if (enable && !reset) model_edge(l, r, cyc);
    tick(hold);
    advance = 1'b0;
    tick(gap);
  endtask

  // Single edge into an idle, drained pass-through path: head must appear exactly 3 cycles later.
  task automatic send_check0(logic [23:0] l, logic [23:0] r, logic [23:0] exp, string name);
    send(l, r, 1, 2);
    chk({name, "_vld"}, {31'd0, vld0}, 32'd1);
    chk(name, {8'd0, out0}, {8'd0, exp});
    tick(3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic set_enable(logic e);
    tick(4);
    enable = e;
    if (!e) begin
      grp_n[0] = 0;
      grp_n[1] = 0;
    end
    tick(2);
  endtask

  task automatic check_reset_outputs(string name);
    chk({name, "_out0"}, {8'd0, out0}, 32'd0);
    chk({name, "_vld0"}, {31'd0, vld0}, 32'd0);
    chk({name, "_ovf0"}, {16'd0, ovf0}, 32'd0);
    chk({name, "_out2"}, {8'd0, out2}, 32'd0);
    chk({name, "_vld2"}, {31'd0, vld2}, 32'd0);
    chk({name, "_ovf2"}, {16'd0, ovf2}, 32'd0);
  endtask

  initial begin
    int lat;
    int c;
    logic [23:0] l, r;
    model_clear();
    tick(2);
    check_reset_outputs("reset");

    // Advance held high through reset release must not produce a sample.
    reset = 1'b0;
    tick(3);
    advance = 1'b0;
    tick(3);
    chk("adv_thru_reset_vld0", {31'd0, vld0}, 32'd0);

    // Pass-through latency with a 2-cycle strobe.
    adc_left = 24'h000010; adc_right = 24'h000020; advance = 1'b1;
    model_edge(adc_left, adc_right, cyc);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 2) advance = 1'b0;
      if (vld0 && lat == 0) begin
        lat = i;
        chk("t1_value", {8'd0, out0}, 32'h000018);
      end
    end
    chk("t1_latency", lat, 32'd3);

    // Overflow corners through the mono adder.
    send_check0(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, "max_pos");
    send_check0(24'h800000, 24'h800000, 24'h800000, "max_neg");
    send_check0(24'hFFFFFF, 24'h000000, 24'hFFFFFF, "floor_half");
    tick(4);

    // Decimate-by-4 group of monos 4, 8, 12, -4.
    send(24'h000004, 24'h000004, 1, 1);
    send(24'h000008, 24'h000008, 1, 1);
    send(24'h00000C, 24'h00000C, 1, 3);
    chk("t3_no_partial", {31'd0, vld2}, 32'd0);
    send(24'hFFFFFC, 24'hFFFFFC, 1, 0);
    tick(2);
    chk("t3_vld", {31'd0, vld2}, 32'd1);
    chk("t3_avg", {8'd0, out2}, 32'h000005);
    tick(4);

    // Reset mid-group with pass-through FIFO holding data.
    sample_ready = 1'b0;
    send(24'h000100, 24'h000300, 1, 1);
    send(24'h000050, 24'h000010, 1, 4);
    do_reset();
    check_reset_outputs("mid_reset");
    sample_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(24'(i * 40 + 3), 24'(24'hFFFF00 + i), 1, 2);
    tick(6);

    // Full FIFO: ten groups with no consumer.
    do_reset();
    sample_ready = 1'b0;
    for (int i = 0; i < 40; i++) send(24'($urandom), 24'($urandom), 1, 1);
    tick(5);
    chk("t4_ovf_d2", {16'd0, ovf2}, 32'd2);
    chk("t4_ovf_d0", {16'd0, ovf0}, 32'd32);
    // Push lands while full and the consumer pops in that same cycle.
    for (int i = 0; i < 3; i++) send(24'($urandom), 24'($urandom), 1, 1);
    adc_left = 24'h012345; adc_right = 24'hFEDCBA; advance = 1'b1;
    model_edge(adc_left, adc_right, cyc);
    tick(1);
    advance = 1'b0;
    tick(1);
    sample_ready = 1'b1;
    tick(1);
    sample_ready = 1'b0;
    tick(4);
    chk("t4_simul_ovf_d2", {16'd0, ovf2}, 32'd2);
    chk("t4_simul_ovf_d0", {16'd0, ovf0}, 32'd35);
    sample_ready = 1'b1;
    tick(20);

    // Enable drop at phase 3: partial group discarded, stored sample kept.
    do_reset();
    sample_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(24'(i * 1000), 24'(i * 3000), 1, 1);
    for (int i = 0; i < 3; i++) send(24'h400000, 24'h400000, 1, 1);
    set_enable(1'b0);
    send(24'h111111, 24'h222222, 2, 2);
    set_enable(1'b1);
    chk("t6_fifo_kept_vld2", {31'd0, vld2}, 32'd1);
    for (int i = 0; i < 4; i++) send(24'(24'hFFFFF0 - i), 24'(i), 1, 1);
    tick(4);
    sample_ready = 1'b1;
    tick(20);

    // Randomised traffic with random backpressure and occasional corner values.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: l = 24'h7FFFFF;
        1: l = 24'h800000;
        default: l = 24'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: r = 24'h7FFFFF;
        1: r = 24'h800000;
        default: r = 24'($urandom);
      endcase
      sample_ready = ($urandom_range(0, 3) != 0);
      send(l, r, $urandom_range(1, 3), $urandom_range(1, 3));
    end
    sample_ready = 1'b1;
    c = cyc;
    while ((vld0 || vld2) && cyc < c + 200) tick(1);
    tick(4);
    chk("drain_vld0", {31'd0, vld0}, 32'd0);
    chk("drain_vld2", {31'd0, vld2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
